stopwatch_bcd_counter: RTL

Parametrised decimal stopwatch core. It divides the board clock down to an exact tick period and counts ticks in an N-digit BCD chain. Start/stop, clear and lap come from debounced-upstream active-low pushbuttons. It sits between the KEY inputs and the bcd7seg digit decoders (one decoder per digit, instantiated by the parent) and drives the HEX displays through them.

---
 rtl/stopwatch_bcd_counter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/stopwatch_bcd_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stopwatch_bcd_counter: exact-period tick divider feeding an N-digit BCD   |
// | chain, with optional lap hold (macro STOPWATCH_LAP_HOLD_EN). Rev 1.0      |
// +--------------------------------------------------------------------------+
module stopwatch_bcd_counter #(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_HZ     = 50000000,
    parameter int TICK_HZ    = 100
) (
    input  logic                    CLOCK_50,
    input  logic                    resetn,
    input  logic                    key_start_n,
    input  logic                    key_clear_n,
    input  logic                    key_lap_n,
    output logic [4*NUM_DIGITS-1:0] disp_bcd,
    output logic [4*NUM_DIGITS-1:0] live_bcd,
    output logic                    running,
    output logic                    lap_active,
    output logic                    overflow,
    output logic                    tick
);
    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    if ((CLK_HZ % TICK_HZ) != 0) begin : g_err_ratio
        $error("stopwatch_bcd_counter: CLK_HZ must be a multiple of TICK_HZ");
    end
    if (DIV < 2) begin : g_err_div
        $error("stopwatch_bcd_counter: CLK_HZ/TICK_HZ must be at least 2");
    end
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_err_digits
        $error("stopwatch_bcd_counter: NUM_DIGITS must be 1..8");
    end

`ifdef STOPWATCH_LAP_HOLD_EN
    localparam int NKEYS = 3;
    logic [NKEYS-1:0] keys_n;
    assign keys_n = {key_lap_n, key_clear_n, key_start_n};
`else
    localparam int NKEYS = 2;
    logic [NKEYS-1:0] keys_n;
    logic             key_lap_unused;
    assign keys_n         = {key_clear_n, key_start_n};
    assign key_lap_unused = key_lap_n;
`endif

    // Two sync stages plus a history stage; released keys read as 1.
    logic [NKEYS-1:0] sync1_q, sync2_q, sync3_q, press;
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= '1;
            sync2_q <= '1;
            sync3_q <= '1;
        end else begin
            sync1_q <= keys_n;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end
    assign press = sync3_q & ~sync2_q;

    logic start_p, clear_p;
    assign start_p = press[0];
    assign clear_p = press[1];

    logic [DIV_W-1:0]        div_q, div_d;
    logic [4*NUM_DIGITS-1:0] cnt_q, cnt_d, cnt_inc;
    logic                    running_q, running_d;
    logic                    ovf_q, ovf_d;
    logic                    tick_q, tick_d;
    logic                    carry;

    always_comb begin
        cnt_inc = cnt_q;
        carry   = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (cnt_q[4*i +: 4] == 4'd9) begin
                    cnt_inc[4*i +: 4] = 4'd0;
                end else begin
                    cnt_inc[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
    end

    always_comb begin
        running_d = running_q ^ start_p;
        div_d     = div_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        tick_d    = 1'b0;
        if (running_q) begin
            if (div_q == DIV_LAST) begin
                div_d  = '0;
                tick_d = 1'b1;
                cnt_d  = cnt_inc;
                if (carry) begin
                    ovf_d = 1'b1;
                end
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
        // Clear discards a coincident tick entirely, including its pulse.
        if (clear_p) begin
            div_d  = '0;
            cnt_d  = '0;
            ovf_d  = 1'b0;
            tick_d = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            div_q     <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
            ovf_q     <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            running_q <= running_d;
            ovf_q     <= ovf_d;
            tick_q    <= tick_d;
        end
    end

    assign live_bcd = cnt_q;
    assign running  = running_q;
    assign overflow = ovf_q;
    assign tick     = tick_q;

`ifdef STOPWATCH_LAP_HOLD_EN
    logic [4*NUM_DIGITS-1:0] lap_q, lap_d;
    logic                    lap_active_q, lap_active_d;

    always_comb begin
        lap_d        = lap_q;
        lap_active_d = lap_active_q;
        if (press[2]) begin
            if (lap_active_q) begin
                lap_active_d = 1'b0;
            end else begin
                lap_d        = cnt_q;
                lap_active_d = 1'b1;
            end
        end
        if (clear_p) begin
            lap_active_d = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            lap_q        <= '0;
            lap_active_q <= 1'b0;
        end else begin
            lap_q        <= lap_d;
            lap_active_q <= lap_active_d;
        end
    end

    assign lap_active = lap_active_q;
    assign disp_bcd   = lap_active_q ? lap_q : cnt_q;
`else
    assign lap_active = 1'b0;
    assign disp_bcd   = cnt_q;
`endif

endmodule
`default_nettype wire
